// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and legal WIDTH range.
package div_pkg;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_addsub.sv
// (N)-bit adder/subtractor shared by the non-restoring steps and the final remainder correction.
module div_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/param_divider.sv
// Multi-cycle non-restoring divider, signed or unsigned, with divide-by-zero and
// signed-overflow short-circuits. One quotient bit is produced per ITER cycle.
module param_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

    div_state_e       state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             sgn_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH:0]   d_q;
    logic [CW-1:0]    cnt_q;

    logic             dvd_neg_s;
    logic             dvs_neg_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic             ovf_s;
    logic [WIDTH:0]   a_sh_s;
    logic [WIDTH:0]   add_a_s;
    logic             add_sub_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] rem_mag_s;
    logic             q_neg_s;

    assign dvd_neg_s = sgn_q & dvd_q[WIDTH-1];
    assign dvs_neg_s = sgn_q & dvs_q[WIDTH-1];
    assign dvd_mag_s = dvd_neg_s ? -dvd_q : dvd_q;
    assign dvs_mag_s = dvs_neg_s ? -dvs_q : dvs_q;
    assign ovf_s     = sgn_q && (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_q == {WIDTH{1'b1}});
    assign a_sh_s    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign q_neg_s   = dvd_neg_s ^ dvs_neg_s;
    // Only a negative partial remainder needs the divisor added back.
    assign rem_mag_s = a_q[WIDTH] ? sum_s[WIDTH-1:0] : a_q[WIDTH-1:0];

    // Operand selection for the shared adder: shifted step in ITER, plain A + D in FIX.
    always_comb begin
        add_a_s   = a_sh_s;
        add_sub_s = ~a_q[WIDTH];
        if (state_q == S_FIX) begin
            add_a_s   = a_q;
            add_sub_s = 1'b0;
        end else begin
            add_a_s   = a_sh_s;
            add_sub_s = ~a_q[WIDTH];
        end
    end

    div_addsub #(
        .N(WIDTH + 1)
    ) u_addsub (
        .a  (add_a_s),
        .b  (d_q),
        .sub(add_sub_s),
        .sum(sum_s)
    );

    // Control FSM with datapath registers and registered result/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            sgn_q       <= 1'b0;
            a_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dvd_q       <= dividend;
                        dvs_q       <= divisor;
                        sgn_q       <= SIGNED_EN & is_signed;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (dvs_q == '0) begin
                        quotient    <= '1;
                        remainder   <= dvd_q;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_q     <= S_DONE;
                    end else if (ovf_s) begin
                        quotient  <= dvd_q;
                        remainder <= '0;
                        overflow  <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        a_q     <= '0;
                        q_q     <= dvd_mag_s;
                        d_q     <= {1'b0, dvs_mag_s};
                        cnt_q   <= '0;
                        state_q <= S_ITER;
                    end
                end
                S_ITER: begin
                    a_q   <= sum_s;
                    q_q   <= {q_q[WIDTH-2:0], ~sum_s[WIDTH]};
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient  <= q_neg_s ? -q_q : q_q;
                    remainder <= dvd_neg_s ? -rem_mag_s : rem_mag_s;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_divider.sv
// Self-checking bench for param_divider: directed vectors, randomized operations against an
// arithmetic reference model, start-while-busy, back-to-back and reset-abort scenarios.
module tb_param_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    logic        start8;
    logic        is_signed8;
    logic [7:0]  dividend8;
    logic [7:0]  divisor8;
    logic        busy8;
    logic        done8;
    logic [7:0]  quotient8;
    logic [7:0]  remainder8;
    logic        dbz8;
    logic        ovf8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    param_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    param_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(is_signed8),
        .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
        .quotient(quotient8), .remainder(remainder8),
        .div_by_zero(dbz8), .overflow(ovf8)
    );

    // Reference: plain arithmetic with truncation toward zero, plus the two special cases.
    function automatic void model32(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output logic ov, output int lat);
        longint sa;
        longint sb;
        dz  = 1'b0;
        ov  = 1'b0;
        lat = 35;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 2;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; ov = 1'b1; lat = 2;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Runs one 32-bit operation from a negedge in IDLE; optionally pulses start at cycle glitch_at.
    task automatic op32(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int glitch_at,
                        output logic [31:0] q, output logic [31:0] r, output logic dz, output logic ov,
                        output int lat, output logic busy_seen);
        is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
        lat = 0; busy_seen = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (lat == 1) busy_seen = busy;
            if (done) break;
            if (lat == glitch_at) begin
                start = 1'b1; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
            end
        end
        q = quotient; r = remainder; dz = div_by_zero; ov = overflow;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
        start8 = 1'b0; is_signed8 = 1'b0; dividend8 = 8'd0; divisor8 = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, div_by_zero, overflow} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {busy, done, div_by_zero, overflow});
        else n_pass++;
        n_checks++;
        if ({quotient, remainder} !== 64'd0)
            $display("FAIL reset_results: got q=%h r=%h want 0", quotient, remainder);
        else n_pass++;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_start_ignored: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_vectors();
        logic [31:0] q, r; logic dz, ov, bs; int lat;
        op32(1'b0, 32'd4802, 32'd172, 0, q, r, dz, ov, lat, bs);
        n_checks++;
        if ({q, r, dz, ov} !== {32'd27, 32'd158, 2'b00})
            $display("FAIL vec_4802_172: got q=%0d r=%0d dz=%b ov=%b want 27 158 0 0", q, r, dz, ov);
        else n_pass++;
        n_checks++;
        if (lat !== 35) $display("FAIL vec_4802_latency: got %0d want 35", lat); else n_pass++;
        n_checks++;
        if (bs !== 1'b1) $display("FAIL vec_busy: got %b want 1", bs); else n_pass++;

        op32(1'b1, 32'hFFFF_FFF9, 32'd2, 0, q, r, dz, ov, lat, bs);
        n_checks++;
        if ({q, r, dz, ov} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 2'b00})
            $display("FAIL vec_m7_2: got q=%h r=%h dz=%b ov=%b want fffffffd ffffffff 0 0", q, r, dz, ov);
        else n_pass++;

        op32(1'b0, 32'd100, 32'd0, 0, q, r, dz, ov, lat, bs);
        n_checks++;
        if ({q, r, dz, ov, lat} !== {32'hFFFF_FFFF, 32'd100, 2'b10, 32'd2})
            $display("FAIL vec_div0: got q=%h r=%0d dz=%b ov=%b lat=%0d want ffffffff 100 1 0 2", q, r, dz, ov, lat);
        else n_pass++;

        op32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, q, r, dz, ov, lat, bs);
        n_checks++;
        if ({q, r, dz, ov, lat} !== {32'h8000_0000, 32'd0, 2'b01, 32'd2})
            $display("FAIL vec_ovf: got q=%h r=%h dz=%b ov=%b lat=%0d want 80000000 0 0 1 2", q, r, dz, ov, lat);
        else n_pass++;

        op32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, q, r, dz, ov, lat, bs);
        n_checks++;
        if ({q, r, dz, ov, lat} !== {32'd0, 32'h8000_0000, 2'b00, 32'd35})
            $display("FAIL vec_ovf_unsigned: got q=%h r=%h dz=%b ov=%b lat=%0d want 0 80000000 0 0 35", q, r, dz, ov, lat);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er; logic dz, ov, edz, eov, bs; bit sgn; int lat, elat, sel;
        for (int i = 0; i < 60; i++) begin
            sgn = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            a = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel < 5) b = $urandom_range(1, 300);
            else if (sel < 7) b = -32'($urandom_range(1, 300));
            else b = $urandom;
            if (b == 32'd0 && sel != 0) b = 32'd1;
            model32(sgn, a, b, eq, er, edz, eov, elat);
            op32(sgn, a, b, $urandom_range(1, 30), q, r, dz, ov, lat, bs);
            n_checks++;
            if ({q, r, dz, ov, lat} !== {eq, er, edz, eov, elat})
                $display("FAIL random_%0d: s=%b %h/%h got q=%h r=%h dz=%b ov=%b lat=%0d want q=%h r=%h dz=%b ov=%b lat=%0d",
                         i, sgn, a, b, q, r, dz, ov, lat, eq, er, edz, eov, elat);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, r; logic dz, ov, bs; int lat;
        op32(1'b0, 32'd77, 32'd0, 0, q, r, dz, ov, lat, bs);
        op32(1'b1, 32'd1000, 32'hFFFF_FFF9, 0, q, r, dz, ov, lat, bs);
        n_checks++;
        if ({q, r, dz, ov, lat} !== {32'hFFFF_FF72, 32'd6, 2'b00, 32'd35})
            $display("FAIL back_to_back: got q=%h r=%0d dz=%b ov=%b lat=%0d want ffffff72 6 0 0 35", q, r, dz, ov, lat);
        else n_pass++;
        op32(1'b0, 32'hFFFF_FFFF, 32'd1, 0, q, r, dz, ov, lat, bs);
        n_checks++;
        if ({q, r, lat} !== {32'hFFFF_FFFF, 32'd0, 32'd35})
            $display("FAIL back_to_back_max: got q=%h r=%h lat=%0d want ffffffff 0 35", q, r, lat);
        else n_pass++;
    endtask

    task automatic test_width8_ignore_start();
        int lat;
        is_signed8 = 1'b0; dividend8 = 8'd255; divisor8 = 8'd16; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; dividend8 = 8'd7; divisor8 = 8'd1;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            start8 = (lat == 5);
            if (done8) break;
        end
        start8 = 1'b0;
        n_checks++;
        if ({quotient8, remainder8, dbz8, ovf8} !== {8'd15, 8'd15, 2'b00})
            $display("FAIL w8_255_16: got q=%0d r=%0d dz=%b ov=%b want 15 15 0 0", quotient8, remainder8, dbz8, ovf8);
        else n_pass++;
        n_checks++;
        if (lat !== 11) $display("FAIL w8_latency: got %0d want 11", lat); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy8, done8} !== 2'b00) $display("FAIL w8_idle_after: got %b want 00", {busy8, done8});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r; logic dz, ov, bs, saw_done; int lat;
        is_signed = 1'b0; dividend = 32'd500; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 9; c++) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_mid_busy: got %b want 00", {busy, done});
        else n_pass++;
        rst = 1'b0; start = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) $display("FAIL reset_mid_no_done: got activity=%b want 0", saw_done);
        else n_pass++;
        op32(1'b0, 32'd500, 32'd7, 0, q, r, dz, ov, lat, bs);
        n_checks++;
        if ({q, r, dz, ov, lat} !== {32'd71, 32'd3, 2'b00, 32'd35})
            $display("FAIL reset_mid_restart: got q=%0d r=%0d dz=%b ov=%b lat=%0d want 71 3 0 0 35", q, r, dz, ov, lat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_width8_ignore_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
